pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  - Holds the architectural PC and fetches one instruction at a time from instruction memory.
//  - Drives Current_PC into the PC ALU and registers its Updated_PC result as the next fetch address.
//  - Issues imem req/gnt requests, captures imem rvalid data, and presents instruction + PC to decode with valid/ready.
//  - Sits between the PC ALU (upstream of the PC) and decode (downstream); at most one request outstanding.
// PARAMETERS
//  - RESET_PC    32'h0000_0000  PC loaded on reset.
//  - PERF_CNT_W  32             Width of the retired-fetch counter Fetch_Count.
// PORTS
//  - clk             in   1   Clock; all state changes on the rising edge.
//  - rst_n           in   1   Asynchronous active-low reset.
//  - Updated_PC      in   32  Next PC from the PC ALU; sampled on the decode handshake.
//  - Redirect_Valid  in   1   Forced PC load (trap/flush); highest priority.
//  - Redirect_PC     in   32  Target for Redirect_Valid.
//  - Current_PC      out  32  PC register; feeds the PC ALU and the imem address.
//  - Imem_Req        out  1   Fetch request valid.
//  - Imem_Addr       out  32  Fetch address; equals Current_PC.
//  - Imem_Gnt        in   1   Request accepted this cycle.
//  - Imem_Rvalid     in   1   Read data valid; arrives 1 or more cycles after the grant.
//  - Imem_Rdata      in   32  Instruction word.
//  - Instr_Valid     out  1   Instr/Instr_PC valid to decode.
//  - Instr_Ready     in   1   Decode accepts the instruction.
//  - Instr           out  32  Fetched instruction, registered.
//  - Instr_PC        out  32  PC of Instr, registered.
//  - Fetch_Count     out  PERF_CNT_W  Count of decode handshakes; wraps modulo 2^PERF_CNT_W.
// BEHAVIOUR
//  - Reset values: Current_PC = RESET_PC, state = REQ, Instr_Valid = 0, Instr = 0, Instr_PC = 0, Fetch_Count = 0, Imem_Req = 0.
//  - Imem_Req is combinational from state: it is 1 only in REQ.
//  - FSM states: REQ, WAIT, HOLD, DRAIN.
//    - REQ: Imem_Req = 1. Imem_Gnt moves to WAIT. The request is held stable until granted.
//    - WAIT: Imem_Rvalid captures Rdata into Instr and Current_PC into Instr_PC, sets Instr_Valid, and moves to HOLD.
//    - HOLD: Instr_Valid = 1; Instr and Instr_PC are stable. Instr_Ready & Instr_Valid loads Current_PC <= Updated_PC, clears Instr_Valid, increments Fetch_Count, and moves to REQ.
//    - DRAIN: waits for the orphaned response, discards it on Imem_Rvalid, then moves to REQ.
//  - Minimum throughput: REQ -> WAIT -> HOLD -> REQ, i.e. 3 cycles per instruction with a gnt in the first cycle and rvalid one cycle later.
//  - Redirect_Valid, handled in any state. It overrides a simultaneous decode handshake, and Fetch_Count does not increment.
//    - Current_PC <= Redirect_PC and Instr_Valid <= 0.
//    - From WAIT without Imem_Rvalid in the same cycle: go to DRAIN.
//    - From WAIT with Imem_Rvalid in the same cycle: drop the data and go to REQ.
//    - From DRAIN: stay in DRAIN.
//    - Otherwise: go to REQ.
//  - Redirect in REQ during the grant cycle: the granted request is orphaned, so go to DRAIN.
//  - Imem_Rvalid outside WAIT/DRAIN is ignored.
//  - Reset asserted mid-transaction returns to the reset values immediately; the memory is reset by the same rst_n.
//  - Address arithmetic is done by the PC ALU; this block performs no PC addition.
// CONFIGURATION
//  - FETCH_ALIGN_CHECK_EN defined:
//    - A handshake or redirect whose target has bits[1:0] != 0 does not load the PC.
//    - The FSM enters HALT, Imem_Req = 0, and output Fetch_Misalign (1 bit, reset 0) goes high.
//    - Only reset or a redirect to an aligned target leaves HALT and clears Fetch_Misalign.
//  - FETCH_ALIGN_CHECK_EN undefined: no Fetch_Misalign port and no HALT state; PC bits[1:0] are forced to 2'b00 on every load.
// TESTING
//  - Reset release, gnt same cycle, rvalid +1, ready=1, Updated_PC=4 -> Imem_Addr 0 then 4; Instr_PC=0; Fetch_Count=1 after 3 cycles.
//  - Instr_Ready=0 for 5 cycles in HOLD -> Instr/Instr_PC stable, Imem_Req=0, Current_PC unchanged.
//  - Imem_Gnt withheld 4 cycles -> Imem_Req and Imem_Addr held constant; no state advance.
//  - Redirect_PC=0x100 in WAIT, rvalid 2 cycles later -> data dropped, Instr_Valid stays 0, next Imem_Addr=0x100.
//  - Redirect together with the decode handshake, Updated_PC=0x8 vs Redirect_PC=0x200 -> Current_PC=0x200, Fetch_Count unchanged.
//  - FETCH_ALIGN_CHECK_EN, Updated_PC=0x6 -> Fetch_Misalign=1, Imem_Req=0; redirect to 0x40 -> resumes at 0x40.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch with a valid/ready hand-off to decode.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned PC targets halt fetch and raise Fetch_Misalign.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           Updated_PC,
  input  logic                  Redirect_Valid,
  input  logic [31:0]           Redirect_PC,
  output logic [31:0]           Current_PC,
  output logic                  Imem_Req,
  output logic [31:0]           Imem_Addr,
  input  logic                  Imem_Gnt,
  input  logic                  Imem_Rvalid,
  input  logic [31:0]           Imem_Rdata,
  output logic                  Instr_Valid,
  input  logic                  Instr_Ready,
  output logic [31:0]           Instr,
  output logic [31:0]           Instr_PC,
  output logic [PERF_CNT_W-1:0] Fetch_Count,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                  Fetch_Misalign,
`endif
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    , S_HALT = 3'd4
`endif
  } state_t;

  state_t                r_state;
  logic [31:0]           r_pc;
  logic                  r_instr_valid;
  logic [31:0]           r_instr;
  logic [31:0]           r_instr_pc;
  logic [PERF_CNT_W-1:0] r_fetch_count;

  state_t      w_state_nxt;
  logic        w_pc_load;
  logic [31:0] w_pc_nxt;
  logic        w_capture;
  logic        w_clr_valid;
  logic        w_cnt_inc;
  logic        w_handshake;

  // Decode handshake: Instr/Instr_PC transfer on a cycle where Instr_Valid and
  // Instr_Ready are both high; Instr_Valid never drops without that transfer
  // unless a redirect flushes the held instruction.
  assign w_handshake = r_instr_valid & Instr_Ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    w_clr_valid = 1'b0;
    w_cnt_inc   = 1'b0;

    case (r_state)
      S_REQ: begin
        if (Redirect_Valid) w_state_nxt = Imem_Gnt ? S_DRAIN : S_REQ;
        else if (Imem_Gnt)  w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (Redirect_Valid) begin
          w_state_nxt = Imem_Rvalid ? S_REQ : S_DRAIN;
        end else if (Imem_Rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Redirect_Valid) begin
          w_state_nxt = S_REQ;
        end else if (w_handshake) begin
          w_pc_load   = 1'b1;
          w_pc_nxt    = Updated_PC;
          w_clr_valid = 1'b1;
          w_cnt_inc   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      // The orphaned response must be consumed even if a redirect lands with it.
      S_DRAIN: begin
        if (Imem_Rvalid) w_state_nxt = S_REQ;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_HALT: begin
        if (Redirect_Valid) w_state_nxt = S_REQ;
      end
`endif
      default: w_state_nxt = S_REQ;
    endcase

    if (Redirect_Valid) begin
      w_pc_load   = 1'b1;
      w_pc_nxt    = Redirect_PC;
      w_clr_valid = 1'b1;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    if (w_pc_load && (w_pc_nxt[1:0] != 2'b00)) begin
      w_pc_load   = 1'b0;
      w_state_nxt = S_HALT;
    end
`else
    w_pc_nxt = w_pc_nxt & 32'hFFFF_FFFC;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_load) r_pc <= w_pc_nxt;
      if (w_capture && !Redirect_Valid) begin
        r_instr       <= Imem_Rdata;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
      end else if (w_clr_valid) begin
        r_instr_valid <= 1'b0;
      end
      if (w_cnt_inc) r_fetch_count <= r_fetch_count + PERF_CNT_W'(1);
    end
  end

  // Request is masked while reset is held so it reads 0 during reset.
  assign Imem_Req    = (r_state == S_REQ) & rst_n;
  assign Imem_Addr   = r_pc;
  assign Current_PC  = r_pc;
  assign Instr_Valid = r_instr_valid;
  assign Instr       = r_instr;
  assign Instr_PC    = r_instr_pc;
  assign Fetch_Count = r_fetch_count;
  assign o_dbg_state = r_state;
`ifdef FETCH_ALIGN_CHECK_EN
  assign Fetch_Misalign = (r_state == S_HALT);
`endif

endmodule
